// File: rtl/pmci_host_adapter_pkg.sv
// Shared types and constants for the PMCI host-side 64-bit to CSR-side 32-bit AVMM adapter.
package pmci_host_adapter_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_TIMEOUT_CYC = 256;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // LO/HI are each split into a command phase and a read-data wait phase.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_CMD,
    ST_LO_DAT,
    ST_HI_CMD,
    ST_HI_DAT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/pmci_host_adapter_wdog.sv
// Wait-cycle watchdog for one downstream half; used only when PMCI_HOST_ADAPTER_TIMEOUT_EN is defined.
module pmci_host_adapter_wdog
  import pmci_host_adapter_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires during the LIMIT-th waiting cycle so the FSM leaves on that edge.
  assign o_expired = i_count && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/pmci_host_avmm_adapter.sv
// Splits 64-bit host AVMM accesses into up to two 32-bit CSR accesses (LO then HI).
// Optional downstream timeout: define PMCI_HOST_ADAPTER_TIMEOUT_EN.
module pmci_host_avmm_adapter
  import pmci_host_adapter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_write,
  input  logic              s_read,
  input  logic [63:0]       s_writedata,
  input  logic [7:0]        s_byteenable,
  output logic              s_waitrequest,
  output logic [63:0]       s_readdata,
  output logic              s_readdatavalid,
  output logic [1:0]        s_response,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic              m_read,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              proto_err
);

  state_t            r_state, w_next;
  logic              r_ready, r_is_write, r_proto_err;
  logic [ADDR_W-4:0] r_waddr;
  logic [63:0]       r_wdata, r_rdata;
  logic [7:0]        r_be;
  logic              w_accept, w_cmd, w_hi, w_timeout;
  logic              w_unused;

  assign w_accept = (r_state == ST_IDLE) && r_ready && (s_read || s_write);
  assign w_cmd    = (r_state == ST_LO_CMD) || (r_state == ST_HI_CMD);
  assign w_hi     = (r_state == ST_HI_CMD);
  assign w_unused = ^{s_address[2:0], TIMEOUT_CYC[0]};

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (|s_byteenable[3:0])      w_next = ST_LO_CMD;
          else if (|s_byteenable[7:4]) w_next = ST_HI_CMD;
          else                         w_next = ST_RESP;
        end
      end
      ST_LO_CMD: begin
        if (w_timeout)           w_next = ST_RESP;
        else if (!m_waitrequest) w_next = !r_is_write ? ST_LO_DAT
                                        : (|r_be[7:4] ? ST_HI_CMD : ST_RESP);
      end
      ST_LO_DAT: begin
        if (w_timeout)            w_next = ST_RESP;
        else if (m_readdatavalid) w_next = |r_be[7:4] ? ST_HI_CMD : ST_RESP;
      end
      ST_HI_CMD: begin
        if (w_timeout)           w_next = ST_RESP;
        else if (!m_waitrequest) w_next = r_is_write ? ST_RESP : ST_HI_DAT;
      end
      ST_HI_DAT: begin
        if (w_timeout || m_readdatavalid) w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_is_write  <= 1'b0;
      r_proto_err <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_be        <= '0;
    end else begin
      r_ready     <= 1'b1;
      r_state     <= w_next;
      r_proto_err <= w_accept && s_read && s_write;
      if (w_accept) begin
        r_waddr    <= s_address[ADDR_W-1:3];
        r_wdata    <= s_writedata;
        r_be       <= s_byteenable;
        r_is_write <= s_write;
        r_rdata    <= '0;
      end else if (w_timeout && !r_is_write) begin
        r_rdata <= '0;
      end else if (m_readdatavalid && (r_state == ST_LO_DAT)) begin
        r_rdata[31:0] <= m_readdata;
      end else if (m_readdatavalid && (r_state == ST_HI_DAT)) begin
        r_rdata[63:32] <= m_readdata;
      end
    end
  end

`ifdef PMCI_HOST_ADAPTER_TIMEOUT_EN
  logic       w_waiting, w_wd_clear;
  logic [1:0] r_resp;

  assign w_waiting  = (w_cmd && m_waitrequest) ||
                      (((r_state == ST_LO_DAT) || (r_state == ST_HI_DAT)) && !m_readdatavalid);
  // Restart the count at every half boundary as well as between transactions.
  assign w_wd_clear = (r_state == ST_IDLE) || (r_state == ST_RESP) ||
                      ((w_next == ST_HI_CMD) && (r_state != ST_HI_CMD));

  pmci_host_adapter_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clear),
    .i_count  (w_waiting),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_resp <= RESP_OKAY;
    else if (w_accept)                  r_resp <= RESP_OKAY;
    else if (w_timeout && !r_is_write)  r_resp <= RESP_SLVERR;
  end

  assign s_response = r_resp;
`else
  assign w_timeout  = 1'b0;
  assign s_response = RESP_OKAY;
`endif

  assign s_waitrequest   = !((r_state == ST_IDLE) && r_ready);
  assign s_readdata      = r_rdata;
  assign s_readdatavalid = (r_state == ST_RESP) && !r_is_write;
  assign proto_err       = r_proto_err;

  assign m_read       = w_cmd && !r_is_write;
  assign m_write      = w_cmd && r_is_write;
  assign m_address    = w_cmd ? {r_waddr, w_hi, 2'b00} : '0;
  assign m_byteenable = w_cmd ? (w_hi ? r_be[7:4] : r_be[3:0]) : '0;
  assign m_writedata  = m_write ? (w_hi ? r_wdata[63:32] : r_wdata[31:0]) : '0;

endmodule
